// File: rtl/nf_clap_pkg.sv
// Shared types, default parameter values and the saturating-magnitude helper
// for the clap pattern detector.
package nf_clap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFRACT = 2'd1,
        ARMED   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam int unsigned DEF_SAMPLE_W        = 16;
    localparam int unsigned DEF_THRESH          = 12000;
    localparam int unsigned DEF_REFRACT_SAMPLES = 2400;
    localparam int unsigned DEF_WINDOW_SAMPLES  = 48000;
    localparam int unsigned DEF_CLAPS_N         = 2;
    localparam int unsigned CLAP_CNT_W          = 4;

    // |x| for a w-bit two's-complement value held sign-extended in 32 bits;
    // the most negative code clips to the largest positive code.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] x,
                                            input int unsigned        w);
        logic [31:0] lim;
        logic [31:0] mag;
        lim = (32'd1 << (w - 32'd1)) - 32'd1;
        mag = x[31] ? 32'(-x) : 32'(x);
        if (mag > lim) begin
            mag = lim;
        end
        return mag;
    endfunction

endpackage

// File: rtl/nf_abs_sat.sv
// Combinational saturating magnitude of a signed audio sample.
module nf_abs_sat
    import nf_clap_pkg::*;
#(
    parameter int unsigned SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic signed [SAMPLE_W-1:0] sample_in,
    output logic        [SAMPLE_W-2:0] mag_c
);

    localparam int unsigned MAG_W = SAMPLE_W - 1;

    always_comb begin
        mag_c = MAG_W'(abs_sat(32'(sample_in), SAMPLE_W));
    end

endmodule

// File: rtl/nf_clap_pattern_detector.sv
// N-clap pattern detector: magnitude threshold, refractory lockout, time window.
// Optional peak_level output when NF_CLAP_PEAK_OUT_EN is defined.
module nf_clap_pattern_detector
    import nf_clap_pkg::*;
#(
    parameter int unsigned SAMPLE_W        = DEF_SAMPLE_W,
    parameter int unsigned THRESH          = DEF_THRESH,
    parameter int unsigned REFRACT_SAMPLES = DEF_REFRACT_SAMPLES,
    parameter int unsigned WINDOW_SAMPLES  = DEF_WINDOW_SAMPLES,
    parameter int unsigned CLAPS_N         = DEF_CLAPS_N
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       enable,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    output logic                       clap_pulse,
    output logic                       pattern_detected,
    output logic [CLAP_CNT_W-1:0]      clap_count,
    output logic                       busy
`ifdef NF_CLAP_PEAK_OUT_EN
    ,
    output logic [SAMPLE_W-2:0]        peak_level
`endif
);

    localparam int unsigned CNT_W = $clog2(WINDOW_SAMPLES + 1);
    localparam int unsigned MAG_W = SAMPLE_W - 1;

    localparam logic [MAG_W-1:0]      THRESH_V  = MAG_W'(THRESH);
    localparam logic [CNT_W-1:0]      REFRACT_V = CNT_W'(REFRACT_SAMPLES);
    localparam logic [CNT_W-1:0]      WINDOW_V  = CNT_W'(WINDOW_SAMPLES);
    localparam logic [CLAP_CNT_W-1:0] CLAPS_V   = CLAP_CNT_W'(CLAPS_N);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        win_q, win_d;
    logic [CNT_W-1:0]        ref_q, ref_d;
    logic [CLAP_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    clap_q, clap_d;
    logic                    pat_q, pat_d;
    logic                    busy_q, busy_d;

    logic [MAG_W-1:0]        mag_c;
    logic                    hit_c;
    logic [CNT_W-1:0]        win_inc_c;
    logic [CNT_W-1:0]        ref_inc_c;
    logic [CLAP_CNT_W-1:0]   cnt_inc_c;

    nf_abs_sat #(
        .SAMPLE_W (SAMPLE_W)
    ) u_abs_sat (
        .sample_in (sample_in),
        .mag_c     (mag_c)
    );

    // Event qualification and saturating counter increments.
    always_comb begin
        hit_c     = sample_valid & enable & (mag_c >= THRESH_V);
        win_inc_c = (win_q == WINDOW_V)  ? win_q : win_q + CNT_W'(1);
        ref_inc_c = (ref_q == REFRACT_V) ? ref_q : ref_q + CNT_W'(1);
        cnt_inc_c = cnt_q + CLAP_CNT_W'(1);
    end

    // Next-state and pulse generation; counters move only on valid samples.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ref_d   = ref_q;
        cnt_d   = cnt_q;
        clap_d  = 1'b0;
        pat_d   = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            win_d   = '0;
            ref_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hit_c) begin
                        clap_d = 1'b1;
                        cnt_d  = CLAP_CNT_W'(1);
                        win_d  = '0;
                        ref_d  = '0;
                        if (CLAPS_N == 1) begin
                            pat_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = LOCKOUT;
                        end else begin
                            state_d = REFRACT;
                        end
                    end
                end

                REFRACT: begin
                    if (sample_valid) begin
                        win_d = win_inc_c;
                        ref_d = ref_inc_c;
                        if (win_inc_c == WINDOW_V) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            win_d   = '0;
                            ref_d   = '0;
                        end else if (ref_inc_c == REFRACT_V) begin
                            state_d = ARMED;
                        end
                    end
                end

                ARMED: begin
                    if (sample_valid) begin
                        win_d = win_inc_c;
                        // Expiry outranks a hit landing on the same sample.
                        if (win_inc_c == WINDOW_V) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            win_d   = '0;
                            ref_d   = '0;
                        end else if (hit_c) begin
                            clap_d = 1'b1;
                            ref_d  = '0;
                            if (cnt_inc_c == CLAPS_V) begin
                                pat_d   = 1'b1;
                                cnt_d   = '0;
                                win_d   = '0;
                                state_d = LOCKOUT;
                            end else begin
                                cnt_d   = cnt_inc_c;
                                state_d = REFRACT;
                            end
                        end
                    end
                end

                LOCKOUT: begin
                    if (sample_valid) begin
                        ref_d = ref_inc_c;
                        if (ref_inc_c == REFRACT_V) begin
                            state_d = IDLE;
                            ref_d   = '0;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                    win_d   = '0;
                    ref_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            win_q   <= '0;
            ref_q   <= '0;
            cnt_q   <= '0;
            clap_q  <= 1'b0;
            pat_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ref_q   <= ref_d;
            cnt_q   <= cnt_d;
            clap_q  <= clap_d;
            pat_q   <= pat_d;
            busy_q  <= busy_d;
        end
    end

    assign clap_pulse       = clap_q;
    assign pattern_detected = pat_q;
    assign clap_count       = cnt_q;
    assign busy             = busy_q;

`ifdef NF_CLAP_PEAK_OUT_EN
    logic [MAG_W-1:0] run_max_q, run_max_d;
    logic [MAG_W-1:0] peak_q, peak_d;
    logic [MAG_W-1:0] clap_max_c;

    // Running max over the accepted claps of the current window.
    always_comb begin
        clap_max_c = (mag_c > run_max_q) ? mag_c : run_max_q;
        run_max_d  = run_max_q;
        peak_d     = peak_q;
        if (state_d == IDLE) begin
            run_max_d = '0;
        end else if (clap_d) begin
            run_max_d = clap_max_c;
        end
        if (pat_d) begin
            peak_d = clap_max_c;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_max_q <= '0;
            peak_q    <= '0;
        end else begin
            run_max_q <= run_max_d;
            peak_q    <= peak_d;
        end
    end

    assign peak_level = peak_q;
`endif

endmodule

// File: tb/tb_nf_clap_pattern_detector.sv
// Directed bench for nf_clap_pattern_detector with a per-sample scoreboard.
// Build with or without NF_CLAP_PEAK_OUT_EN.
module tb_nf_clap_pattern_detector;

    localparam int SAMPLE_W = 16;
    localparam int THRESH   = 1000;
    localparam int REFRACT  = 4;
    localparam int WINDOW   = 20;
    localparam int CLAPS    = 2;

    typedef struct packed {
        logic       clap;
        logic       pat;
        logic [3:0] cnt;
        logic       busy;
    } exp_t;

    logic                       clk;
    logic                       resetn;
    logic                       enable;
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       clap_pulse;
    logic                       pattern_detected;
    logic [3:0]                 clap_count;
    logic                       busy;
`ifdef NF_CLAP_PEAK_OUT_EN
    logic [SAMPLE_W-2:0]        peak_level;
`endif

    nf_clap_pattern_detector #(
        .SAMPLE_W        (SAMPLE_W),
        .THRESH          (THRESH),
        .REFRACT_SAMPLES (REFRACT),
        .WINDOW_SAMPLES  (WINDOW),
        .CLAPS_N         (CLAPS)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .enable           (enable),
        .sample_valid     (sample_valid),
        .sample_in        (sample_in),
        .clap_pulse       (clap_pulse),
        .pattern_detected (pattern_detected),
        .clap_count       (clap_count),
        .busy             (busy)
`ifdef NF_CLAP_PEAK_OUT_EN
        ,
        .peak_level       (peak_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state, expressed as absolute sample indices.
    int k        = 0;
    int mode     = 0;   // 0 idle, 1 collecting claps, 2 post-pattern lockout
    int f        = 0;   // index of first clap in window
    int l        = 0;   // index of last accepted clap
    int p        = 0;   // index of pattern completion
    int c        = 0;
    int pk       = 0;
    int exp_peak = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mode = 0;
        c    = 0;
        pk   = 0;
    endtask

    task automatic model_step(input int v, output exp_t e);
        int m;
        bit hit;
        m   = (v < 0) ? -v : v;
        if (m > 32767) m = 32767;
        hit = (m >= THRESH);
        e   = '0;
        case (mode)
            0: if (hit) begin
                c = 1; f = k; l = k; pk = m; e.clap = 1'b1; mode = 1;
            end
            1: begin
                if (k - f >= WINDOW) begin
                    mode = 0; c = 0; pk = 0;
                end else if (hit && (k - l > REFRACT)) begin
                    c++; l = k; e.clap = 1'b1;
                    if (m > pk) pk = m;
                    if (c == CLAPS) begin
                        e.pat = 1'b1; c = 0; mode = 2; p = k; exp_peak = pk;
                    end
                end
            end
            2: if (k - p >= REFRACT) begin
                mode = 0; pk = 0;
            end
            default: mode = 0;
        endcase
        e.cnt  = 4'(c);
        e.busy = (mode != 0);
        k++;
    endtask

    task automatic send(input int v);
        exp_t e;
        model_step(v, e);
        exp_q.push_back(e);
        sample_in    = 16'(v);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        sample_in    = '0;
        @(negedge clk);
    endtask

    task automatic quiet(input int n);
        repeat (n) send(0);
    endtask

    task automatic chk_peak(input string tag);
`ifdef NF_CLAP_PEAK_OUT_EN
        chk(tag, 32'(peak_level), 32'(exp_peak));
`else
        chk(tag, 32'(pattern_detected), 32'd0);
`endif
    endtask

    // Scoreboard: compare each valid sample's response; pulses idle otherwise.
    always @(posedge clk) begin
        exp_t e;
        if (resetn && sample_valid) begin
            #1;
            chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("clap_pulse", 32'(clap_pulse), 32'(e.clap));
                chk("pattern_detected", 32'(pattern_detected), 32'(e.pat));
                chk("clap_count", 32'(clap_count), 32'(e.cnt));
                chk("busy", 32'(busy), 32'(e.busy));
            end
        end else if (resetn) begin
            #1;
            chk("clap_pulse_gap", 32'(clap_pulse), 32'd0);
            chk("pattern_gap", 32'(pattern_detected), 32'd0);
        end
    end

    initial begin
        resetn       = 1'b0;
        enable       = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_clap", 32'(clap_pulse), 32'd0);
        chk("rst_pat", 32'(pattern_detected), 32'd0);
        chk("rst_cnt", 32'(clap_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk_peak("rst_peak");
        resetn = 1'b1;
        @(negedge clk);

        // Single hit then window expiry
        send(1500);
        chk("single_cnt", 32'(clap_count), 32'd1);
        quiet(20);
        chk("single_exp_cnt", 32'(clap_count), 32'd0);
        chk("single_exp_busy", 32'(busy), 32'd0);

        // Double clap
        send(1500);
        quiet(5);
        send(-2000);
        chk_peak("double_peak");
        quiet(4);
        chk("double_idle", 32'(busy), 32'd0);

        // Hit inside refractory is ignored
        send(1500);
        quiet(1);
        send(1500);
        chk("refract_cnt", 32'(clap_count), 32'd1);
        quiet(18);
        chk("refract_idle", 32'(busy), 32'd0);

        // Hit on the refractory-end sample ignored, next sample accepted
        send(1500);
        quiet(3);
        send(1200);
        send(1200);
        quiet(4);

        // Most negative sample saturates
        send(-32768);
        quiet(4);
        send(-32768);
        chk_peak("sat_peak");
        quiet(4);

        // Last in-window sample completes
        send(1500);
        quiet(18);
        send(1100);
        quiet(4);

        // Hit on the expiry sample is discarded
        send(1500);
        quiet(19);
        send(1500);
        chk("tie_cnt", 32'(clap_count), 32'd0);
        chk("tie_busy", 32'(busy), 32'd0);
        quiet(2);

        // Asynchronous reset mid-refractory
        send(1500);
        send(0);
        resetn = 1'b0;
        #1;
        model_reset();
        exp_peak = 0;
        chk("arst_clap", 32'(clap_pulse), 32'd0);
        chk("arst_pat", 32'(pattern_detected), 32'd0);
        chk("arst_cnt", 32'(clap_count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk_peak("arst_peak");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Enable dropped for one cycle while armed
        send(1500);
        quiet(4);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        model_reset();
        chk("en_cnt", 32'(clap_count), 32'd0);
        chk("en_busy", 32'(busy), 32'd0);
        send(1500);
        chk("en_hit_cnt", 32'(clap_count), 32'd1);
        quiet(20);
        chk("en_end_busy", 32'(busy), 32'd0);

        repeat (2) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
